// File: rtl/miriscv_lsu_split.sv
// miriscv_lsu_split: load/store unit with wait states, bus errors and optional misaligned split (LSU_MISALIGN_SPLIT_EN)
module miriscv_lsu_split #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [2:0]          lsu_size_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_data_i,
    output logic                lsu_stall_req_o,
    output logic [DATA_W-1:0]   lsu_data_o,
    output logic                lsu_err_o,
    output logic                lsu_misalign_o,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    input  logic                data_err_i,
    input  logic [DATA_W-1:0]   data_rdata_i,
    output logic                data_we_o,
    output logic [DATA_W/8-1:0] data_be_o,
    output logic [ADDR_W-1:0]   data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int LW  = $clog2(DATA_W);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
    localparam int MW    = 2 * NB;
`else
    localparam bit SPLIT = 1'b0;
    localparam int MW    = NB;
`endif
    typedef enum logic [2:0] {
        IDLE,
        ADDR1,
        RESP1,
`ifdef LSU_MISALIGN_SPLIT_EN
        ADDR2,
        RESP2,
`endif
        DONE
    } state_t;
    state_t            state, next;
    logic [OFF-1:0]    off_in, off_q;
    logic [3:0]        bytes, bytes_q;
    logic [4:0]        span;
    logic              illegal, misalign, fin, uns_q, we_q, err_q;
    logic [MW-1:0]     one_w, bm_w;
    logic [ADDR_W-1:0] addr_al, addr_q;
    logic [DATA_W-1:0] wdata_rot, wdata_q, res_q, res_d, low_r, ext_mask;
    logic [NB-1:0]     be1_q;
    logic [6:0]        nbits;
    logic [LW-1:0]     sbit;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [NB-1:0]       be2_q;
    logic                split_q;
    logic [DATA_W-1:0]   lo_buf;
    logic [2*DATA_W-1:0] wide_r;
    assign wide_r         = split_q ? {data_rdata_i, lo_buf} : {{DATA_W{1'b0}}, data_rdata_i};
    assign lsu_misalign_o = 1'b0;
`else
    logic                mis_q;
    logic [DATA_W-1:0]   wide_r;
    assign wide_r         = data_rdata_i;
    assign lsu_misalign_o = state == DONE && mis_q;
`endif
    assign off_in    = lsu_addr_i[OFF-1:0];
    assign bytes     = 4'd1 << lsu_size_i[1:0];
    assign illegal   = lsu_size_i == 3'b111 || (DATA_W == 32 && (lsu_size_i == 3'b011 || lsu_size_i == 3'b110));
    assign span      = 5'(off_in) + 5'(bytes);
    assign misalign  = span > 5'(NB);
    assign one_w     = MW'(1);
    assign bm_w      = ((one_w << bytes) - one_w) << off_in;
    assign addr_al   = {lsu_addr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
    assign wdata_rot = DATA_W'({lsu_data_i, lsu_data_i} >> (DATA_W - 32'({off_in, 3'b000})));
    assign low_r     = DATA_W'(wide_r >> {off_q, 3'b000});
    assign nbits     = {bytes_q, 3'b000};
    assign ext_mask  = ~({DATA_W{1'b1}} << nbits);
    assign sbit      = LW'(nbits - 7'd1);
    assign res_d     = we_q ? '0 : (low_r & ext_mask) | ((!uns_q && low_r[sbit]) ? ~ext_mask : '0);
    assign lsu_stall_req_o = lsu_req_i && state != DONE;
    assign lsu_data_o      = state == DONE ? res_q : '0;
    assign lsu_err_o       = state == DONE && err_q;
    // next state and bus drive: live request in IDLE, latched beat afterwards
    always_comb begin
        next         = state;
        fin          = 1'b0;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        case (state)
            IDLE: if (lsu_req_i) begin
                if (illegal || (misalign && !SPLIT)) next = DONE;
                else begin
                    data_req_o   = 1'b1;
                    data_we_o    = lsu_we_i;
                    data_be_o    = bm_w[NB-1:0];
                    data_addr_o  = addr_al;
                    data_wdata_o = wdata_rot;
                    next         = data_gnt_i ? RESP1 : ADDR1;
                end
            end
            ADDR1: begin
                data_req_o   = 1'b1;
                data_we_o    = we_q;
                data_be_o    = be1_q;
                data_addr_o  = addr_q;
                data_wdata_o = wdata_q;
                next         = data_gnt_i ? RESP1 : ADDR1;
            end
            RESP1: if (data_rvalid_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                fin  = data_err_i || !split_q;
                next = fin ? DONE : ADDR2;
`else
                fin  = 1'b1;
                next = DONE;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ADDR2: begin
                data_req_o   = 1'b1;
                data_we_o    = we_q;
                data_be_o    = be2_q;
                data_addr_o  = addr_q + ADDR_W'(NB);
                data_wdata_o = wdata_q;
                next         = data_gnt_i ? RESP2 : ADDR2;
            end
            RESP2: if (data_rvalid_i) begin
                fin  = 1'b1;
                next = DONE;
            end
`endif
            default: next = IDLE;
        endcase
    end
    // state register, request capture in IDLE, result capture on the final response
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= IDLE;
            addr_q  <= '0;
            be1_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            bytes_q <= '0;
            off_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            be2_q   <= '0;
            split_q <= 1'b0;
            lo_buf  <= '0;
`else
            mis_q   <= 1'b0;
`endif
        end else begin
            state <= next;
            if (state == IDLE && lsu_req_i) begin
                addr_q  <= addr_al;
                be1_q   <= bm_w[NB-1:0];
                wdata_q <= wdata_rot;
                we_q    <= lsu_we_i;
                uns_q   <= lsu_size_i[2];
                bytes_q <= bytes;
                off_q   <= off_in;
                res_q   <= '0;
                err_q   <= illegal;
`ifdef LSU_MISALIGN_SPLIT_EN
                be2_q   <= bm_w[MW-1:NB];
                split_q <= misalign;
`else
                mis_q   <= misalign && !illegal;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state == RESP1 && data_rvalid_i) lo_buf <= data_rdata_i;
`endif
            if (fin) begin
                res_q <= res_d;
                err_q <= data_err_i;
            end
        end
    end
endmodule

// File: tb/tb_miriscv_lsu_split.sv
// tb_miriscv_lsu_split: directed vector table plus wait/error and reset sequences for miriscv_lsu_split
module tb_miriscv_lsu_split;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    logic        clk_i = 1'b0, arst_i = 1'b1;
    logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = '0;
    logic [31:0] lsu_addr_i = '0, lsu_data_i = '0;
    logic        lsu_stall_req_o, lsu_err_o, lsu_misalign_o;
    logic [31:0] lsu_data_o;
    logic        data_req_o, data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;

    miriscv_lsu_split #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
        .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o),
        .lsu_err_o(lsu_err_o), .lsu_misalign_o(lsu_misalign_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_err_i(data_err_i), .data_rdata_i(data_rdata_i), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] we, size, addr, wd, rd1, rd2;
        logic [31:0] beats, a1, be1, wd1, a2, be2;
        logic [31:0] data, err, mis, stall;
    } vec_t;

    localparam int NV = 14;
    vec_t v[NV];
    int checks = 0, failures = 0;
    int nbeats, req_cnt, stall_cnt, unstable, done;
    logic [31:0] b_addr[2], b_be[2], b_wd[2], b_we[2];
    logic [31:0] r_data, r_err, r_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // one access with a simple bus: grant after gwait refused cycles (beat 1 only), rvalid the cycle after grant
    task automatic run(input logic [31:0] we, size, addr, wd, rd1, rd2, input logic e1, input int gwait);
        int cyc, wcnt, first;
        logic rv_next;
        logic [31:0] ca, cb, cw, cwe;
        nbeats = 0; req_cnt = 0; stall_cnt = 0; unstable = 0; done = 0;
        r_data = '0; r_err = '0; r_mis = '0;
        cyc = 0; wcnt = 0; first = 1; rv_next = 1'b0;
        ca = '0; cb = '0; cw = '0; cwe = '0;
        lsu_req_i = 1'b1; lsu_we_i = we[0]; lsu_size_i = size[2:0];
        lsu_addr_i = addr; lsu_data_i = wd;
        while (done == 0 && cyc < 40) begin
            data_rvalid_i = rv_next;
            data_rdata_i  = (nbeats <= 1) ? rd1 : rd2;
            data_err_i    = rv_next && nbeats == 1 && e1;
            data_gnt_i    = 1'b0;
            rv_next       = 1'b0;
            #1;
            if (lsu_stall_req_o) stall_cnt++;
            else begin
                done   = 1;
                r_data = lsu_data_o;
                r_err  = 32'(lsu_err_o);
                r_mis  = 32'(lsu_misalign_o);
            end
            if (data_req_o) begin
                req_cnt++;
                if (first != 0) begin
                    ca = data_addr_o; cb = 32'(data_be_o); cw = data_wdata_o; cwe = 32'(data_we_o);
                    first = 0;
                end else if (ca !== data_addr_o || cb !== 32'(data_be_o) || cw !== data_wdata_o || cwe !== 32'(data_we_o))
                    unstable = 1;
                if (done == 0 && (nbeats > 0 || wcnt >= gwait)) begin
                    data_gnt_i = 1'b1;
                    if (nbeats < 2) begin
                        b_addr[nbeats] = ca; b_be[nbeats] = cb; b_wd[nbeats] = cw; b_we[nbeats] = cwe;
                    end
                    nbeats++;
                    rv_next = 1'b1;
                    first = 1;
                end else wcnt++;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("completed", 32'(done), 32'd1);
        lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        we  size  addr    wd            rd1           rd2           beats          a1     be1          wd1                       a2     be2          data                          err mis       stall
        v[0]  = '{1, 3'b010, 'h100, 'hDEADBEEF, 0,            0,            1,             'h100, 'hF,         'hDEADBEEF,               0,     0,           0,                            0,  0,        2};
        v[1]  = '{0, 3'b000, 'h103, 0,          'h80000000,   0,            1,             'h100, 'h8,         0,                        0,     0,           'hFFFFFF80,                   0,  0,        2};
        v[2]  = '{0, 3'b101, 'h102, 0,          'hABCD0000,   0,            1,             'h100, 'hC,         0,                        0,     0,           'h0000ABCD,                   0,  0,        2};
        v[3]  = '{0, 3'b001, 'h100, 0,          'h12348765,   0,            1,             'h100, 'h3,         0,                        0,     0,           'hFFFF8765,                   0,  0,        2};
        v[4]  = '{0, 3'b100, 'h101, 0,          'h0000F000,   0,            1,             'h100, 'h2,         0,                        0,     0,           'h000000F0,                   0,  0,        2};
        v[5]  = '{1, 3'b000, 'h102, 'h000000A5, 0,            0,            1,             'h100, 'h4,         'h00A50000,               0,     0,           0,                            0,  0,        2};
        v[6]  = '{1, 3'b001, 'h102, 'h0000BEEF, 0,            0,            1,             'h100, 'hC,         'hBEEF0000,               0,     0,           0,                            0,  0,        2};
        v[7]  = '{0, 3'b010, 'h200, 0,          'h76543210,   0,            1,             'h200, 'hF,         0,                        0,     0,           'h76543210,                   0,  0,        2};
        v[8]  = '{0, 3'b111, 'h101, 0,          0,            0,            0,             0,     0,           0,                        0,     0,           0,                            1,  0,        1};
        v[9]  = '{0, 3'b011, 'h100, 0,          0,            0,            0,             0,     0,           0,                        0,     0,           0,                            1,  0,        1};
        v[10] = '{0, 3'b110, 'h100, 0,          0,            0,            0,             0,     0,           0,                        0,     0,           0,                            1,  0,        1};
        v[11] = '{0, 3'b010, 'h102, 0,          'hBBAA0000,   'h0000DDCC,   SPLIT ? 2 : 0, 'h100, 'hC,         0,                        'h104, 'h3,         SPLIT ? 'hDDCCBBAA : 0,       0,  !SPLIT,   SPLIT ? 4 : 1};
        v[12] = '{1, 3'b010, 'h103, 'h11223344, 0,            0,            SPLIT ? 2 : 0, 'h100, 'h8,         'h44112233,               'h104, 'h7,         0,                            0,  !SPLIT,   SPLIT ? 4 : 1};
        v[13] = '{0, 3'b001, 'h103, 0,          'h12000000,   'h00000080,   SPLIT ? 2 : 0, 'h100, 'h8,         0,                        'h104, 'h1,         SPLIT ? 'hFFFF8012 : 0,       0,  !SPLIT,   SPLIT ? 4 : 1};

        #12;
        chk("rst_req", 32'(data_req_o), 0);
        chk("rst_stall", 32'(lsu_stall_req_o), 0);
        chk("rst_data", lsu_data_o, 0);
        chk("rst_err", 32'(lsu_err_o), 0);
        chk("rst_mis", 32'(lsu_misalign_o), 0);
        chk("rst_be", 32'(data_be_o), 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_wdata", data_wdata_o, 0);
        @(posedge clk_i); #1;
        arst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < NV; i++) begin
            run(v[i].we, v[i].size, v[i].addr, v[i].wd, v[i].rd1, v[i].rd2, 1'b0, 0);
            chk($sformatf("v%0d beats", i), 32'(nbeats), v[i].beats);
            chk($sformatf("v%0d req_cycles", i), 32'(req_cnt), v[i].beats);
            chk($sformatf("v%0d stall", i), 32'(stall_cnt), v[i].stall);
            chk($sformatf("v%0d data", i), r_data, v[i].data);
            chk($sformatf("v%0d err", i), r_err, v[i].err);
            chk($sformatf("v%0d mis", i), r_mis, v[i].mis);
            if (v[i].beats >= 1 && nbeats >= 1) begin
                chk($sformatf("v%0d addr1", i), b_addr[0], v[i].a1);
                chk($sformatf("v%0d be1", i), b_be[0], v[i].be1);
                chk($sformatf("v%0d wdata1", i), b_wd[0], v[i].wd1);
                chk($sformatf("v%0d we1", i), b_we[0], v[i].we);
            end
            if (v[i].beats == 2 && nbeats == 2) begin
                chk($sformatf("v%0d addr2", i), b_addr[1], v[i].a2);
                chk($sformatf("v%0d be2", i), b_be[1], v[i].be2);
                chk($sformatf("v%0d wdata2", i), b_wd[1], v[i].wd1);
            end
        end

        // grant withheld three cycles, then beat 1 answers with a bus error
        run(0, 3'b010, SPLIT ? 32'h102 : 32'h100, 0, 32'h11111111, 32'h22222222, 1'b1, 3);
        chk("wait req_cycles", 32'(req_cnt), 4);
        chk("wait stable", 32'(unstable), 0);
        chk("wait beats", 32'(nbeats), 1);
        chk("wait addr1", b_addr[0], 32'h100);
        chk("wait be1", b_be[0], SPLIT ? 32'hC : 32'hF);
        chk("wait err", r_err, 1);
        chk("wait mis", r_mis, 0);
        chk("wait stall", 32'(stall_cnt), 5);

        // asynchronous reset while waiting for the response, then a stray rvalid
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h100; lsu_data_i = '0;
        data_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        data_gnt_i = 1'b0;
        #1;
        chk("resp1 req", 32'(data_req_o), 0);
        arst_i = 1'b1;
        #1;
        chk("arst idle req", 32'(data_req_o), 1);
        chk("arst stall follows req", 32'(lsu_stall_req_o), 1);
        lsu_req_i = 1'b0;
        #1;
        chk("arst stall", 32'(lsu_stall_req_o), 0);
        chk("arst req", 32'(data_req_o), 0);
        chk("arst be", 32'(data_be_o), 0);
        @(posedge clk_i); #1;
        arst_i = 1'b0;
        data_rvalid_i = 1'b1; data_err_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
        #1;
        chk("late rvalid data", lsu_data_o, 0);
        chk("late rvalid err", 32'(lsu_err_o), 0);
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
        #1;
        chk("after rvalid err", 32'(lsu_err_o), 0);
        chk("after rvalid data", lsu_data_o, 0);
        chk("after rvalid stall", 32'(lsu_stall_req_o), 0);
        chk("after rvalid req", 32'(data_req_o), 0);
        @(posedge clk_i); #1;
        run(0, 3'b010, 32'h300, 0, 32'h5A5AA5A5, 0, 1'b0, 0);
        chk("post rst data", r_data, 32'h5A5AA5A5);
        chk("post rst stall", 32'(stall_cnt), 2);
        chk("post rst addr", b_addr[0], 32'h300);
        chk("post rst err", r_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/miriscv_lsu_split.md
Name: miriscv_lsu_split

Overview:
Parametrised next-generation load/store unit for the miriscv core. It sits between the execute stage and the data memory bus. It supports DATA_W of 32 or 64 bits, RISC-V load sign/zero extension, a request/grant/response bus with wait states and bus errors, and optional splitting of misaligned accesses into two bus beats. The core PC is stalled through lsu_stall_req_o until the access completes.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, bus/core data width; legal values 32 or 64; NB = DATA_W/8 byte lanes, OFF = log2(NB)

Ports:
clk_i  in  1  clock, all state on rising edge
arst_i  in  1  asynchronous active-high reset
lsu_req_i  in  1  core requests a memory access
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
lsu_addr_i  in  ADDR_W  byte address
lsu_data_i  in  DATA_W  store data, right-aligned
lsu_stall_req_o  out  1  high while an accepted access is unfinished
lsu_data_o  out  DATA_W  extended load result, valid in DONE
lsu_err_o  out  1  bus error or illegal size, valid in DONE
lsu_misalign_o  out  1  misaligned access rejected, valid in DONE
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant; the address phase completes on req & gnt
data_rvalid_i  in  1  response valid; used for both loads and store acks
data_err_i  in  1  bus error, qualified by data_rvalid_i
data_rdata_i  in  DATA_W  read data, lane-aligned
data_we_o  out  1  write enable
data_be_o  out  NB  byte enables
data_addr_o  out  ADDR_W  NB-aligned address (low OFF bits zero)
data_wdata_o  out  DATA_W  lane-aligned write data

Behaviour:
- Reset: state=IDLE. All outputs 0; internal buffers 0. Reset mid-access aborts the access; a late rvalid after reset is ignored in IDLE.
- States: IDLE, ADDR1, RESP1, ADDR2, RESP2, DONE.
- lsu_stall_req_o = lsu_req_i & (state != DONE).
- Size decode: bytes = 1/2/4/8. Illegal sizes are 111, plus 011 and 110 when DATA_W=32. An illegal size goes IDLE->DONE with lsu_err_o=1 and no bus request.
- Misaligned means addr[OFF-1:0] + bytes > NB (crosses a lane boundary). Alignment within the word is legal. Without the macro this goes IDLE->DONE with lsu_misalign_o=1.
- IDLE: when lsu_req_i is high, address, size, we, wdata and offset are latched. data_req_o is asserted in the same cycle from the live inputs.
  - On gnt: go to RESP1.
  - Without gnt: go to ADDR1.
- ADDR1/ADDR2: hold data_req_o and all data_* outputs stable from the latched registers until gnt, then go to RESP1/RESP2.
- Beat 1: addr = {addr[ADDR_W-1:OFF],0}; be = (byte mask << offset) truncated to NB bits; wdata = lsu_data_i rotated left by offset*8.
- Beat 2 (split only): addr = beat1 addr + NB; be = remaining mask bits; same rotated wdata.
- RESP1 on rvalid:
  - if err, or not split: go to DONE (beat 2 is not issued after an error).
  - else: capture rdata into lo_buf and go to ADDR2. data_req_o is asserted in ADDR2 the following cycle.
- RESP2 on rvalid: go to DONE.
- DONE (exactly 1 cycle) then IDLE:
  - lsu_data_o = {rdata_beat2, lo_buf} (or a single beat) shifted right by offset*8, truncated to bytes, then sign- or zero-extended per size.
  - For stores, lsu_data_o = 0.
  - lsu_err_o is the OR of the err bits seen.
- Changes to lsu_req_i or other inputs after acceptance are ignored. A new request is accepted only in IDLE.
- Zero-wait bus (gnt with req, rvalid next cycle):
  - aligned access: 3 cycles, stall high for 2;
  - split access: 5 cycles, stall high for 4.
- An rvalid outside the RESP states is ignored.

Optional Feature:
Macro LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split into two beats as described, and lsu_misalign_o stays 0.
- Undefined: states ADDR2/RESP2 and lo_buf are removed; misaligned accesses are rejected with lsu_misalign_o=1 in DONE and no bus activity.

Test Plan:
DATA_W=32, zero-wait. SW 0xDEADBEEF at 0x100 -> addr 0x100, be 1111, wdata 0xDEADBEEF, we=1; stall high 2 cycles; lsu_err_o=0.
LB at 0x103, rdata 0x80000000 -> be 1000, lsu_data_o 0xFFFFFF80. LHU at 0x102, rdata 0xABCD0000 -> 0x0000ABCD.
LW at 0x102 (split) -> beat1 0x100 be 1100 rdata 0xBBAA0000; beat2 0x104 be 0011 rdata 0x0000DDCC -> lsu_data_o 0xDDCCBBAA; stall high 4 cycles. Without the macro: lsu_misalign_o=1, data_req_o never high.
SW 0x11223344 at 0x103 -> wdata 0x44112233; beat1 0x100 be 1000; beat2 0x104 be 0111.
gnt withheld 3 cycles, then rvalid with err on beat1 of a split LW -> data_req_o/addr/be stable for 4 cycles; no beat2; lsu_err_o=1 in DONE. lsu_size_i=111 -> lsu_err_o=1 with no request.
arst_i pulsed during RESP1, then rvalid -> state IDLE, all outputs 0, stall follows lsu_req_i only.
